// File: rtl/load_store_unit.sv
// Load/store unit bridging CPU byte/half/word accesses to a 32-bit Wishbone master port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken only when req_valid is high in IDLE (busy low);
    // the result is reported by a single-cycle rsp_valid pulse in DONE.
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state, state_next;
    logic        c_we;
    logic [1:0]  c_size;
    logic        c_unsigned;
    logic [1:0]  c_lane;
    logic [15:0] c_wdata;
    logic [31:0] to_cnt;
    logic        cyc;

    logic        ack_ok;
    logic        timeout_hit;
    logic        misalign;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign ack_ok      = cyc & wb_ack_i;
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Little-endian lane extraction and extension of the returned word.
    always_comb begin
        lane_byte = 8'h00;
        case (c_lane)
            2'd0: lane_byte = wb_dat_i[7:0];
            2'd1: lane_byte = wb_dat_i[15:8];
            2'd2: lane_byte = wb_dat_i[23:16];
            2'd3: lane_byte = wb_dat_i[31:24];
            default: lane_byte = 8'h00;
        endcase
        lane_half = c_lane[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
        case (c_size)
            2'b00:   load_ext = {{24{~c_unsigned & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~c_unsigned & lane_half[15]}}, lane_half};
            default: load_ext = wb_dat_i;
        endcase
    end

    // Sub-word store: overwrite the addressed lanes of the word just read.
    always_comb begin
        merged = wb_dat_i;
        if (c_size == 2'b00) begin
            merged[{c_lane, 3'b000} +: 8] = c_wdata[7:0];
        end else begin
            merged[{c_lane[1], 4'b0000} +: 16] = c_wdata;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misalign) begin
                        state_next = DONE;
                    end else if (req_we && req_size[1]) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (ack_ok) begin
                    state_next = c_we ? WR : DONE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end
            end
            WR: begin
                if (ack_ok || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= IDLE;
            cyc        <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= 32'h0;
            wb_dat_o   <= 32'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            to_cnt     <= 32'h0;
            c_we       <= 1'b0;
            c_size     <= 2'b00;
            c_unsigned <= 1'b0;
            c_lane     <= 2'b00;
            c_wdata    <= 16'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        c_we       <= req_we;
                        c_size     <= req_size;
                        c_unsigned <= req_unsigned;
                        c_lane     <= req_addr[1:0];
                        c_wdata    <= req_wdata[15:0];
                        wb_addr_o  <= {req_addr[31:2], 2'b00};
                        wb_dat_o   <= req_wdata;
                        to_cnt     <= 32'h0;
                        if (misalign) begin
                            cyc       <= 1'b0;
                            wb_we_o   <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            cyc     <= 1'b1;
                            wb_we_o <= req_we & req_size[1];
                        end
                    end
                end
                RD: begin
                    if (ack_ok) begin
                        to_cnt <= 32'h0;
                        if (c_we) begin
                            // Bus cycle continues straight into the write of the merged word.
                            wb_dat_o <= merged;
                            wb_we_o  <= 1'b1;
                        end else begin
                            cyc       <= 1'b0;
                            rsp_rdata <= load_ext;
                            rsp_err   <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        cyc       <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                WR: begin
                    if (ack_ok || timeout_hit) begin
                        cyc       <= 1'b0;
                        wb_we_o   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= ~ack_ok;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_cyc_o  = cyc;
    assign wb_stb_o  = cyc;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);
    assign dbg_state = state;

endmodule
